// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and receiver state encoding.
// The transmitter imports the same package, so both ends agree on framing.
package uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int CLKS_PER_BIT_DEFAULT = 434;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

   typedef enum logic [2:0] {
      RX_IDLE      = ST_IDLE,
      RX_START     = ST_START,
      RX_DATA      = ST_DATA,
      RX_STOP      = ST_STOP,
      RX_WAIT_IDLE = ST_WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; the reset value is chosen per use so that an
// idle line does not look like activity coming out of reset.
module uart_sync2 #(
   parameter int   WIDTH     = 1,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               meta_reg <= RESET_VAL;
               sync_reg <= RESET_VAL;
            end else begin
               meta_reg <= d[gi];
               sync_reg <= meta_reg;
            end
         end

         assign q[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: validates the start bit at mid-bit, samples data and stop bits at mid-bit,
// and strobes valid with the byte or frame_err on a bad stop bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] dataout,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam int IW    = $clog2(DATA_BITS);
   localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

   localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic rx_s;

   rx_state_t            state_reg,     state_next;
   logic [CW-1:0]        cnt_reg,       cnt_next;
   logic [IW-1:0]        bit_idx_reg,   bit_idx_next;
   logic [DATA_BITS-1:0] shift_reg,     shift_next;
   logic [DATA_BITS-1:0] dataout_reg,   dataout_next;
   logic                 valid_reg,     valid_next;
   logic                 frame_err_reg, frame_err_next;

   uart_sync2 #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= RX_IDLE;
         cnt_reg       <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         dataout_reg   <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         bit_idx_reg   <= bit_idx_next;
         shift_reg     <= shift_next;
         dataout_reg   <= dataout_next;
         valid_reg     <= valid_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      bit_idx_next   = bit_idx_reg;
      shift_next     = shift_reg;
      dataout_next   = dataout_reg;
      valid_next     = 1'b0;
      frame_err_next = 1'b0;

      case (state_reg)
         RX_IDLE: begin
            cnt_next = '0;
            if (!rx_s) begin
               state_next = RX_START;
            end
         end

         // A start bit that is high again at mid-bit was a glitch, not a frame.
         RX_START: begin
            if (cnt_reg == CNT_HALF) begin
               cnt_next     = '0;
               bit_idx_next = '0;
               state_next   = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end

         RX_DATA: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next     = '0;
               shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
               bit_idx_next = bit_idx_reg + IW'(1);
               if (bit_idx_reg == IDX_LAST) begin
                  state_next = RX_STOP;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end

         RX_STOP: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next = '0;
               if (rx_s) begin
                  dataout_next = shift_reg;
                  valid_next   = 1'b1;
                  state_next   = RX_IDLE;
               end else begin
                  frame_err_next = 1'b1;
                  state_next     = RX_WAIT_IDLE;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end

         // A break (line held low) must not be mistaken for a stream of start bits.
         RX_WAIT_IDLE: begin
            cnt_next = '0;
            if (rx_s) begin
               state_next = RX_IDLE;
            end
         end

         default: begin
            state_next = RX_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign dataout   = dataout_reg;
   assign valid     = valid_reg;
   assign frame_err = frame_err_reg;
   assign busy      = (state_reg != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames on rx and checks received bytes, strobes and timing.
module tb_uart_rx;

   localparam int C    = 16;
   localparam int HALF = (C - 1) / 2;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] dataout;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int n_compared   = 0;
   int n_mismatched = 0;

   int         cyc = 0;
   int         start_cyc = 0;
   logic [7:0] rx_q[$];
   int         rx_cyc_q[$];
   int         fe_count = 0;
   int         both_count = 0;
   logic       busy_seen = 1'b0;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .dataout   (dataout),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (busy) busy_seen = 1'b1;
      if (valid && frame_err) both_count++;
      if (valid) begin
         rx_q.push_back(dataout);
         rx_cyc_q.push_back(cyc);
         $display("rx byte 0x%02h at cycle %0d", dataout, cyc);
      end
      if (frame_err) begin
         fe_count++;
         $display("rx frame error strobe at cycle %0d", cyc);
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (C) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] data, input logic stop);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(data[i]);
      drive_bit(stop);
   endtask

   initial begin
      int base;
      int fe_base;
      int lat;
      int t_hi;
      int drop;
      logic [7:0] d96;

      rx    = 1'b1;
      reset = 1'b1;
      #20;
      reset = 1'b0;
      @(negedge clk);

      // reset state
      check_value("rst_dataout", dataout, 8'h00);
      check_value("rst_valid", valid, 1'b0);
      check_value("rst_frame_err", frame_err, 1'b0);
      check_value("rst_busy", busy, 1'b0);

      busy_seen = 1'b0;
      repeat (10 * C) @(negedge clk);
      check_value("idle_valid_cnt", rx_q.size(), 0);
      check_value("idle_fe_cnt", fe_count, 0);
      check_value("idle_busy_seen", busy_seen, 1'b0);

      // single frame 0xAA
      send_byte(8'hAA, 1'b1);
      repeat (2 * C) @(negedge clk);
      check_value("aa_count", rx_q.size(), 1);
      check_value("aa_data", rx_q[0], 8'hAA);
      check_value("aa_dataout", dataout, 8'hAA);
      check_value("aa_fe", fe_count, 0);
      check_value("aa_busy", busy, 1'b0);
      lat = rx_cyc_q[0] - start_cyc;
      check_value("aa_latency_win", (lat >= HALF + 9*C + 2) && (lat <= HALF + 9*C + 4), 1'b1);

      // back-to-back, one stop bit, no gap
      base = rx_q.size();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h55, 1'b1);
      repeat (2 * C) @(negedge clk);
      check_value("b2b_count", rx_q.size(), base + 3);
      if (rx_q.size() >= base + 3) begin
         check_value("b2b_d0", rx_q[base], 8'h00);
         check_value("b2b_d1", rx_q[base+1], 8'hFF);
         check_value("b2b_d2", rx_q[base+2], 8'h55);
         check_value("b2b_gap01", (rx_cyc_q[base+1] - rx_cyc_q[base] >= 10*C - 1) &&
                                  (rx_cyc_q[base+1] - rx_cyc_q[base] <= 10*C + 1), 1'b1);
         check_value("b2b_gap12", (rx_cyc_q[base+2] - rx_cyc_q[base+1] >= 10*C - 1) &&
                                  (rx_cyc_q[base+2] - rx_cyc_q[base+1] <= 10*C + 1), 1'b1);
      end
      check_value("b2b_fe", fe_count, 0);

      // glitch shorter than half a bit
      base      = rx_q.size();
      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (C / 4) @(negedge clk);
      rx   = 1'b1;
      t_hi = cyc;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      drop = cyc - t_hi;
      check_value("glitch_busy_seen", busy_seen, 1'b1);
      check_value("glitch_busy_drop", (drop <= HALF + 4) && !busy, 1'b1);
      repeat (2 * C) @(negedge clk);
      check_value("glitch_valid", rx_q.size(), base);
      check_value("glitch_fe", fe_count, 0);

      // framing error followed by a break, then a good frame
      base    = rx_q.size();
      fe_base = fe_count;
      send_byte(8'h3C, 1'b0);
      repeat (3 * C) @(negedge clk);
      check_value("fe_pulse_cnt", fe_count - fe_base, 1);
      check_value("fe_no_valid", rx_q.size(), base);
      check_value("fe_dataout_held", dataout, 8'h55);
      check_value("fe_busy_in_break", busy, 1'b1);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      check_value("fe_busy_released", busy, 1'b0);
      repeat (C) @(negedge clk);
      send_byte(8'hC3, 1'b1);
      repeat (2 * C) @(negedge clk);
      check_value("fe_next_count", rx_q.size(), base + 1);
      check_value("fe_next_data", dataout, 8'hC3);

      // reset during bit 4 of 0x96
      base    = rx_q.size();
      fe_base = fe_count;
      d96     = 8'h96;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d96[i]);
      rx = d96[4];
      repeat (C / 2) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_value("mid_rst_busy", busy, 1'b0);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2 * C) @(negedge clk);
      check_value("mid_rst_no_valid", rx_q.size(), base);
      check_value("mid_rst_no_fe", fe_count, fe_base);
      send_byte(8'h5A, 1'b1);
      repeat (2 * C) @(negedge clk);
      check_value("mid_rst_next_count", rx_q.size(), base + 1);
      check_value("mid_rst_next_data", dataout, 8'h5A);

      check_value("valid_fe_exclusive", both_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
